// File: rtl/sum_operand_decoder.sv
// Receive-side decoder: recovers B = sum - A from a stream of registered-adder
// results, queues {B, ctrl} in a small FIFO and drains it over valid/ready.
module sum_operand_decoder #(
  parameter int N     = 4,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_sum,
  input  logic [N-1:0]  in_valA,
  input  logic [N-1:0]  in_expB,
  input  logic          in_ctrl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_valB,
  output logic [N-1:0]  out_valA,
  output logic          out_mismatch,
  output logic [CW-1:0] out_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [N:0]    entries [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [OW-1:0] occ;
  logic [N-1:0]  diff;
  logic [N:0]    head;
  logic          push;
  logic          pop;

  // One subtractor feeds both the FIFO write data and the expected-B compare.
  assign diff      = in_sum - in_valA;

  assign in_ready  = (occ < FULL);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = entries[rd_ptr];
  assign out_valB  = head[N:1];

  always_ff @(posedge clk) begin
    if (rst && push) begin
      entries[wr_ptr] <= {diff, in_ctrl};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occ          <= '0;
      out_valA     <= '0;
      out_mismatch <= 1'b0;
      out_count    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (diff != in_expB) begin
          out_mismatch <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_count <= out_count + CW'(1);
        if (head[0]) begin
          out_valA <= head[N:1];
        end
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_operand_decoder.sv
// Scoreboard bench for sum_operand_decoder: directed beats push hand-computed B
// values into a queue, and a negedge monitor checks every popped head against it.
module tb_sum_operand_decoder;

  typedef struct packed {
    logic [3:0] b;
    logic       ctrl;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sum;
  logic [3:0] in_valA;
  logic [3:0] in_expB;
  logic       in_ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_valB;
  logic [3:0] out_valA;
  logic       out_mismatch;
  logic [7:0] out_count;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   model_vala;
  int   model_count;

  sum_operand_decoder #(.N(4), .DEPTH(2), .CW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_valA      (in_valA),
    .in_expB      (in_expB),
    .in_ctrl      (in_ctrl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_valB     (out_valB),
    .out_valA     (out_valA),
    .out_mismatch (out_mismatch),
    .out_count    (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one beat and holds it until accepted; the expected B goes to the scoreboard.
  task automatic applyStimulus(input logic [3:0] sum, input logic [3:0] a,
                               input logic [3:0] expb, input logic ctrl,
                               input logic [3:0] want);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_sum   = sum;
    in_valA  = a;
    in_expB  = expb;
    in_ctrl  = ctrl;
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{b: want, ctrl: ctrl});
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles expected acceptance");
    end
  endtask

  task automatic doReset(input int cycles);
    rst       = 1'b0;
    in_valid  = 1'b0;
    exp_q.delete();
    model_vala  = 0;
    model_count = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pop: got out_valB=%0d expected no output", out_valB);
      end else begin
        exp_t item;
        item = exp_q.pop_front();
        checkOutput("pop out_valB", int'(out_valB), int'(item.b));
        checkOutput("pop out_valA", int'(out_valA), model_vala);
        checkOutput("pop out_count", int'(out_count), model_count);
        model_count = (model_count + 1) % 256;
        if (item.ctrl) model_vala = int'(item.b);
      end
    end
  end

  initial begin
    logic [3:0] s;
    logic [3:0] a;
    logic [3:0] w;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_valA   = '0;
    in_expB   = '0;
    in_ctrl   = 1'b0;
    out_ready = 1'b0;

    doReset(2);
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_valA", int'(out_valA), 0);
    checkOutput("reset out_mismatch", int'(out_mismatch), 0);
    checkOutput("reset out_count", int'(out_count), 0);

    // 3 - 9 wraps to 10
    out_ready = 1'b1;
    applyStimulus(4'd3, 4'd9, 4'd10, 1'b1, 4'd10);
    checkOutput("wrap out_valid", int'(out_valid), 1);
    checkOutput("wrap out_valB", int'(out_valB), 10);
    @(posedge clk); #1;
    checkOutput("wrap out_valA", int'(out_valA), 10);
    checkOutput("wrap out_count", int'(out_count), 1);
    checkOutput("wrap out_mismatch", int'(out_mismatch), 0);
    checkOutput("wrap drained", int'(out_valid), 0);

    applyStimulus(4'd7, 4'd2, 4'd5, 1'b0, 4'd5);
    applyStimulus(4'd15, 4'd1, 4'd14, 1'b1, 4'd14);
    checkOutput("ctrl0 holds out_valA", int'(out_valA), 10);
    checkOutput("ctrl0 out_count", int'(out_count), 2);
    @(posedge clk); #1;
    checkOutput("ctrl1 out_valA", int'(out_valA), 14);
    checkOutput("ctrl1 out_count", int'(out_count), 3);

    out_ready = 1'b0;
    applyStimulus(4'd1, 4'd0, 4'd1, 1'b0, 4'd1);
    applyStimulus(4'd0, 4'd1, 4'd15, 1'b1, 4'd15);
    checkOutput("full in_ready", int'(in_ready), 0);
    checkOutput("full out_valid", int'(out_valid), 1);
    fork
      applyStimulus(4'd8, 4'd8, 4'd0, 1'b0, 4'd0);
      begin
        repeat (2) @(posedge clk);
        #2;
        checkOutput("held in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
      end
    join
    checkOutput("push_pop in_ready", int'(in_ready), 1);
    checkOutput("push_pop out_valid", int'(out_valid), 1);
    checkOutput("push_pop head", int'(out_valB), 0);
    repeat (2) @(posedge clk); #1;
    checkOutput("full drained", int'(out_valid), 0);
    checkOutput("full out_count", int'(out_count), 6);
    checkOutput("full out_valA", int'(out_valA), 15);
    checkOutput("full out_mismatch", int'(out_mismatch), 0);

    applyStimulus(4'd4, 4'd1, 4'd2, 1'b0, 4'd3);
    checkOutput("mismatch set", int'(out_mismatch), 1);
    applyStimulus(4'd5, 4'd2, 4'd3, 1'b1, 4'd3);
    checkOutput("mismatch sticky", int'(out_mismatch), 1);
    repeat (2) @(posedge clk); #1;
    checkOutput("mismatch out_valA", int'(out_valA), 3);
    doReset(1);
    checkOutput("mismatch cleared", int'(out_mismatch), 0);
    checkOutput("reset2 out_count", int'(out_count), 0);
    checkOutput("reset2 out_valA", int'(out_valA), 0);

    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      s = 4'(i);
      a = 4'(i * 3);
      w = 4'(16 - ((2 * i) % 16));
      applyStimulus(s, a, w, s[0], w);
    end
    @(posedge clk); #1;
    checkOutput("count 255", int'(out_count), 255);
    checkOutput("stream out_mismatch", int'(out_mismatch), 0);
    applyStimulus(4'd2, 4'd3, 4'd15, 1'b1, 4'd15);
    @(posedge clk); #1;
    checkOutput("count wrap", int'(out_count), 0);
    checkOutput("wrap-pop out_valA", int'(out_valA), 15);

    out_ready = 1'b0;
    applyStimulus(4'd6, 4'd1, 4'd5, 1'b1, 4'd5);
    applyStimulus(4'd9, 4'd4, 4'd5, 1'b1, 4'd5);
    checkOutput("preflush in_ready", int'(in_ready), 0);
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 4'd11;
    in_valA   = 4'd2;
    in_expB   = 4'd0;
    in_ctrl   = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    model_vala  = 0;
    model_count = 0;
    @(posedge clk); #1;
    checkOutput("flush out_valid", int'(out_valid), 0);
    checkOutput("flush in_ready", int'(in_ready), 1);
    checkOutput("flush out_valA", int'(out_valA), 0);
    checkOutput("flush out_count", int'(out_count), 0);
    checkOutput("flush out_mismatch", int'(out_mismatch), 0);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-flush out_valid", int'(out_valid), 0);
    checkOutput("post-flush out_mismatch", int'(out_mismatch), 0);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
